// File: rtl/ssdma_pkg.sv
// Shared definitions for the scatter/gather DMA movers.
package ssdma_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_XFER  = 2'b01,
        S_FLUSH = 2'b10,
        S_DONE  = 2'b11
    } ss_state_t;

    localparam int DC_WR_BIT  = 9;
    localparam int DC_LEN_LSB = 12;
    localparam int DC_LEN_MSB = 23;

endpackage

// File: rtl/ss_write_stage.sv
// Single-entry output stage: holds the popped word until it is pushed.
module ss_write_stage #(
    parameter int DW = 64
) (
    input  logic          wb_clk_i,
    input  logic          wb_rstn_i,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          lin,
    output logic [DW-1:0] data,
    output logic          last,
    output logic          pend
);

    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic          pend_q, pend_d;

    // A pending word always retires in its cycle, so pend simply follows load.
    always_comb begin
        data_d = data_q;
        last_d = last_q;
        pend_d = load;
        if (load) begin
            data_d = din;
            last_d = lin;
        end
    end

    // Stage registers; reset drops any staged word.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            data_q <= '0;
            last_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            last_q <= last_d;
            pend_q <= pend_d;
        end
    end

    assign data = data_q;
    assign last = last_q;
    assign pend = pend_q;

endmodule

// File: rtl/ss_write.sv
// Destination-side mover: source FIFO -> stage -> destination FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   S_IDLE  | waiting for m_enable with this mover selected
//   S_XFER  | popping words while rem != 0 and no early end seen
//   S_FLUSH | final word staged, waiting for it to be pushed
//   S_DONE  | m_endn pulsed once, waiting for m_enable to drop
module ss_write
    import ssdma_pkg::*;
#(
    parameter int DW = 64,
    parameter int LW = 12
) (
    input  logic          wb_clk_i,
    input  logic          wb_rstn_i,
    input  logic          m_enable,
    input  logic [23:0]   dc,
    output logic          m_src_getn,
    input  logic [DW-1:0] m_src,
    input  logic          m_src_last,
    input  logic          m_src_almost_empty,
    input  logic          m_src_empty,
    output logic          m_dst_putn,
    output logic [DW-1:0] m_dst,
    output logic          m_dst_last,
    input  logic          m_dst_almost_full,
    input  logic          m_dst_full,
    output logic          m_endn
);

    localparam logic [LW:0] REM_MAX = {1'b1, {LW{1'b0}}};
    localparam logic [LW:0] REM_ONE = (LW+1)'(1);

    ss_state_t     state_q, state_d;
    logic [LW:0]   rem_q, rem_d;
    logic          ended_q, ended_d;
    logic          sel;
    logic [LW-1:0] len_field;
    logic          pop;
    logic          pop_last;
    logic          endn;
    logic [DW-1:0] stage_data;
    logic          stage_last;
    logic          stage_pend;

    logic unused_ok;
    assign unused_ok = &{1'b0, m_src_almost_empty,
                         dc[DC_LEN_LSB-1:DC_WR_BIT+1], dc[DC_WR_BIT-1:0]};

    assign sel       = dc[DC_WR_BIT];
    assign len_field = LW'(dc[DC_LEN_MSB:DC_LEN_LSB]);

    // Next-state, rem counter and pop decision; almost_full reserves the in-flight slot.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ended_d  = (state_q == S_DONE);
        endn     = 1'b1;
        pop      = (state_q == S_XFER) && sel && m_enable && !m_src_empty &&
                   (rem_q != '0) && !m_dst_full && !m_dst_almost_full;
        pop_last = (rem_q == REM_ONE) | m_src_last;
        if (pop) begin
            rem_d = rem_q - REM_ONE;
        end
        case (state_q)
            S_IDLE: begin
                if (m_enable && sel) begin
                    rem_d   = (len_field == '0) ? REM_MAX : {1'b0, len_field};
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (!m_enable) begin
                    state_d = S_IDLE;
                end else if (pop && pop_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!m_enable) begin
                    state_d = S_IDLE;
                end else if (!stage_pend) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                endn = ended_q;
                if (!m_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!sel) begin
            state_d = S_IDLE;
        end
    end

    // FSM, counter and completion-pulse registers.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ended_q <= ended_d;
        end
    end

    ss_write_stage #(.DW(DW)) u_stage (
        .wb_clk_i  (wb_clk_i),
        .wb_rstn_i (wb_rstn_i),
        .load      (pop),
        .din       (m_src),
        .lin       (pop_last),
        .data      (stage_data),
        .last      (stage_last),
        .pend      (stage_pend)
    );

    assign m_src_getn = sel ? ~pop        : 1'bz;
    assign m_dst_putn = sel ? ~stage_pend : 1'bz;
    assign m_dst      = sel ? stage_data  : {DW{1'bz}};
    assign m_dst_last = sel ? stage_last  : 1'bz;
    assign m_endn     = sel ? endn        : 1'bz;

endmodule

// File: tb/tb_ss_write.sv
module tb_ss_write;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_enable = 1'b0;
    logic [23:0]   dc = 24'h000200;
    logic [DW-1:0] m_src = '0;
    logic          m_src_last = 1'b0;
    logic          m_src_almost_empty = 1'b0;
    logic          m_src_empty = 1'b1;
    logic          m_dst_almost_full = 1'b0;
    logic          m_dst_full = 1'b0;
    wire           m_src_getn;
    wire           m_dst_putn;
    wire  [DW-1:0] m_dst;
    wire           m_dst_last;
    wire           m_endn;

    always #5 clk = ~clk;

    ss_write #(.DW(DW), .LW(12)) dut (
        .wb_clk_i           (clk),
        .wb_rstn_i          (rst_n),
        .m_enable           (m_enable),
        .dc                 (dc),
        .m_src_getn         (m_src_getn),
        .m_src              (m_src),
        .m_src_last         (m_src_last),
        .m_src_almost_empty (m_src_almost_empty),
        .m_src_empty        (m_src_empty),
        .m_dst_putn         (m_dst_putn),
        .m_dst              (m_dst),
        .m_dst_last         (m_dst_last),
        .m_dst_almost_full  (m_dst_almost_full),
        .m_dst_full         (m_dst_full),
        .m_endn             (m_endn)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t src_q[$];
    word_t exp_q[$];
    word_t mon_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dcount = 0;
    int pop_cnt = 0;
    int push_cnt = 0;
    int endn_cnt = 0;
    int first_push_cyc = -1;
    int last_push_cyc = -100;
    bit bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Source and destination FIFO models around the DUT
    initial begin
        forever begin
            @(negedge clk);
            m_src_empty = (src_q.size() == 0) || (bp_mode && $urandom_range(0, 4) == 0);
            if (src_q.size() > 0) begin
                m_src      = src_q[0].data;
                m_src_last = src_q[0].last;
            end else begin
                m_src      = '0;
                m_src_last = 1'b0;
            end
            m_dst_full        = (dcount >= 8);
            m_dst_almost_full = (dcount >= 7) || (bp_mode && (cyc % 2) == 1);
            #1;
            if (rst_n && dc[9]) begin
                if (m_src_getn === 1'b0) begin
                    checks++;
                    if (m_src_empty || m_dst_almost_full || m_dst_full) begin
                        errors++;
                        $display("FAIL pop_guard: pop with empty=%0b afull=%0b full=%0b required no pop",
                                 m_src_empty, m_dst_almost_full, m_dst_full);
                    end
                    if (src_q.size() > 0) void'(src_q.pop_front());
                    pop_cnt++;
                end
                if (m_dst_putn === 1'b0) begin
                    checks++;
                    if (m_dst_full) begin
                        errors++;
                        $display("FAIL push_into_full: putn=0 with full=1 required putn=1");
                    end
                    dcount++;
                end
            end
            if (dcount > 0 && (!bp_mode || $urandom_range(0, 3) != 0)) dcount--;
        end
    end

    // Scoreboard monitor: compares every push against the expected queue
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && dc[9]) begin
                if (m_dst_putn === 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_push: data=%h last=%0b required no push", m_dst, m_dst_last);
                    end else begin
                        mon_w = exp_q.pop_front();
                        if (m_dst !== mon_w.data || m_dst_last !== mon_w.last) begin
                            errors++;
                            $display("FAIL push_word: got %h/%0b expected %h/%0b",
                                     m_dst, m_dst_last, mon_w.data, mon_w.last);
                        end
                    end
                    if (first_push_cyc < 0) first_push_cyc = cyc;
                    if (m_dst_last === 1'b1) last_push_cyc = cyc;
                    push_cnt++;
                end
                if (m_endn === 1'b0) begin
                    endn_cnt++;
                    checks++;
                    if (cyc - last_push_cyc != 2) begin
                        errors++;
                        $display("FAIL endn_timing: endn %0d cycles after last push expected 2",
                                 cyc - last_push_cyc);
                    end
                end
            end
        end
    end

    task automatic fill_src(input int n, input int last_pos);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.data = {$urandom, $urandom};
            w.last = (i + 1 == last_pos);
            src_q.push_back(w);
        end
    endtask

    // Reference: the first n source words, last flag on the final one only
    task automatic expect_words(input int n, input bit mark_last);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w = src_q[i];
            w.last = mark_last && (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic run_xfer(input string name, input int len_field, input int nwords,
                            input int last_pos, input bit bp);
        int leff, n, e0, to;
        logic [11:0] lf;
        leff = (len_field == 0) ? 4096 : len_field;
        n = leff;
        if (last_pos > 0 && last_pos < n) n = last_pos;
        if (nwords < n) n = nwords;
        e0 = endn_cnt;
        src_q.delete();
        exp_q.delete();
        fill_src(nwords, last_pos);
        expect_words(n, 1'b1);
        first_push_cyc = -1;
        lf = len_field[11:0];
        @(negedge clk);
        bp_mode  = bp;
        dc       = {lf, 2'b00, 1'b1, 9'h000};
        m_enable = 1'b1;
        to = 0;
        while (endn_cnt == e0 && to < leff * 4 + 100) begin
            @(negedge clk);
            to++;
        end
        if (endn_cnt == e0) begin
            errors++;
            $display("FAIL %s_timeout: no m_endn after %0d cycles", name, to);
        end
        repeat (3) @(negedge clk);
        m_enable = 1'b0;
        repeat (3) @(negedge clk);
        bp_mode = 1'b0;
        chk({name, "_endn_pulses"}, endn_cnt - e0, 1);
        chk({name, "_words_missing"}, exp_q.size(), 0);
        chk({name, "_src_left"}, src_q.size(), nwords - n);
        if (!bp) chk({name, "_back_to_back"}, last_push_cyc - first_push_cyc, n - 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, e0, to, ln, nw, lp;
        word_t w;

        #12;
        chk("rst_getn", m_src_getn, 1);
        chk("rst_putn", m_dst_putn, 1);
        chk("rst_dst",  m_dst, 0);
        chk("rst_last", m_dst_last, 0);
        chk("rst_endn", m_endn, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer("len4", 4, 6, 0, 1'b0);
        run_xfer("early_end", 8, 8, 3, 1'b0);
        run_xfer("backpressure", 20, 24, 0, 1'b1);
        run_xfer("len1", 1, 3, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            ln = $urandom_range(1, 40);
            nw = ln + $urandom_range(0, 5);
            lp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ln) : 0;
            run_xfer("random", ln, nw, lp, 1'($urandom_range(0, 1)));
        end

        run_xfer("len0", 0, 4100, 0, 1'b0);

        // Abort after two pops
        src_q.delete();
        exp_q.delete();
        fill_src(6, 0);
        expect_words(2, 1'b0);
        base = pop_cnt;
        e0 = endn_cnt;
        @(negedge clk);
        dc = {12'd8, 2'b00, 1'b1, 9'h000};
        m_enable = 1'b1;
        to = 0;
        while (pop_cnt - base < 2 && to < 50) begin
            @(negedge clk);
            to++;
        end
        m_enable = 1'b0;
        if (pop_cnt - base < 2) begin
            errors++;
            $display("FAIL abort_timeout: %0d pops expected 2", pop_cnt - base);
        end
        repeat (6) @(negedge clk);
        chk("abort_pops", pop_cnt - base, 2);
        chk("abort_words_missing", exp_q.size(), 0);
        chk("abort_no_endn", endn_cnt - e0, 0);
        chk("abort_src_left", src_q.size(), 4);

        // After an abort the block must be back in IDLE and start cleanly
        run_xfer("after_abort", 3, 4, 0, 1'b0);

        // Asynchronous reset in the middle of a transfer
        src_q.delete();
        exp_q.delete();
        fill_src(8, 0);
        expect_words(8, 1'b1);
        base = push_cnt;
        @(negedge clk);
        dc = {12'd8, 2'b00, 1'b1, 9'h000};
        m_enable = 1'b1;
        to = 0;
        while (push_cnt - base < 3 && to < 50) begin
            @(negedge clk);
            to++;
        end
        chk("reset_pre_pushes", push_cnt - base >= 3, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_getn", m_src_getn, 1);
        chk("arst_putn", m_dst_putn, 1);
        chk("arst_dst",  m_dst, 0);
        chk("arst_last", m_dst_last, 0);
        chk("arst_endn", m_endn, 1);
        exp_q.delete();
        src_q.delete();
        m_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Deselected: bus released and no transfer starts
        fill_src(4, 0);
        dc = 24'h000000;
        m_enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (m_src_getn !== 1'bz || m_dst_putn !== 1'bz || m_dst_last !== 1'bz ||
            m_endn !== 1'bz || m_dst !== {DW{1'bz}}) begin
            errors++;
            $display("FAIL deselect_hiz: getn=%b putn=%b last=%b endn=%b required z",
                     m_src_getn, m_dst_putn, m_dst_last, m_endn);
        end
        m_enable = 1'b0;
        @(negedge clk);
        dc = 24'h000200;
        repeat (2) @(negedge clk);
        chk("deselect_src_left", src_q.size(), 4);
        chk("deselect_no_push", exp_q.size(), 0);

        run_xfer("reselect", 2, 4, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_write.md
# ss_write

Destination-side mover for the DMA data path: pops 64-bit words from the source FIFO and pushes them into the destination FIFO. It pushes a descriptor-programmed number of words, or stops earlier on a source end-of-stream. It marks the final word with `m_dst_last` and pulses `m_endn` on completion. It is selected by descriptor control bit `dc[9]` and shares the `m_*` FIFO bus with the other movers, so it drives that bus only while selected.

## Interface
Parameters:
- `DW`, 64, data width.
- `LW`, 12, length field width; length 0 means 2^LW words.

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rstn_i`  in  1  reset, asynchronous, active-low.
- `m_enable`  in  1  mover enable; a rising level starts a transfer.
- `dc`  in  24  descriptor control; `dc[9]` selects this block, `dc[23:12]` is the length in words.
- `m_src_getn`  out  1  source pop, active-low.
- `m_src`  in  DW  source head word; valid while `m_src_empty`=0.
- `m_src_last`  in  1  head word is the final word of the stream.
- `m_src_almost_empty`  in  1  unused; tie-off only.
- `m_src_empty`  in  1  source empty.
- `m_dst_putn`  out  1  destination push, active-low.
- `m_dst`  out  DW  push data, registered.
- `m_dst_last`  out  1  pushed word is the last word, qualified by `m_dst_putn`=0.
- `m_dst_almost_full`  in  1  at most one free destination slot.
- `m_dst_full`  in  1  destination full.
- `m_endn`  out  1  completion, active-low, one-cycle pulse.

## Operation
- **Bus ownership.** While `dc[9]`=0, all outputs are high-Z and the state machine is held in IDLE.
- **IDLE.** Requires `m_enable`=1 and `dc[9]`=1. Load `rem` (LW+1 bits) with `dc[23:12]`, or with 2^LW if that field is 0. Go to XFER.
- **XFER.** A pop occurs when all of the following hold:
  - `!m_src_empty`
  - `rem`≠0
  - `!m_dst_full` and `!m_dst_almost_full`

  On a pop:
  - drive `m_src_getn`=0 combinationally;
  - capture `m_src` into the stage register and set `pend`=1;
  - decrement `rem`;
  - set `last_q` = (`rem`==1) | `m_src_last`.

  If `last_q` is set by the pop, go to FLUSH.
- **Push.** Any cycle with `pend`=1 drives `m_dst_putn`=0, `m_dst`=stage, and `m_dst_last`=`last_q`. `pend` clears at the edge unless a new pop refills the stage in that same cycle.
- **Slot guarantee.** The almost_full guard on pops reserves a slot for the in-flight word, so a push is never refused and `m_dst_full` is never sampled at push time.
- **FLUSH.** Wait for the final push to retire (`pend`=0), then go to DONE.
- **DONE.** Drive `m_endn`=0 for exactly one cycle. Stay in DONE with `m_endn`=1 until `m_enable`=0, then go to IDLE.
- **Abort.** If `m_enable` drops in XFER or FLUSH, the pending word still pushes, carrying its current `last_q`. The block then goes to IDLE with no `m_endn` pulse.
- **Early end.** On `m_src_last`, the block stops regardless of `rem`; the residual `rem` is discarded.

## Timing
- **Reset values** (output bus selected): `m_src_getn`=1, `m_dst_putn`=1, `m_dst`=0, `m_dst_last`=0, `m_endn`=1; state=IDLE, `pend`=0.
- **Reset mid-transfer:** an asynchronous clear; the staged word is dropped.
- **Latency:** a pop in cycle N produces a push in cycle N+1.
- **Throughput:** 1 word/cycle while the source is non-empty and the destination is not almost full.
- **Start:** the first pop can occur no earlier than the cycle after `m_enable` is sampled high in IDLE.
- **Completion:** `m_endn` is low the cycle after FLUSH sees `pend`=0, i.e. 2 cycles after the final push cycle.
- **Simultaneous events:** a pop and a push in the same cycle are legal and refill the stage. Source empty and destination almost full in the same cycle simply stall the pop.

## Structure
- **Shared package `ssdma_pkg`:**
  - state encodings S_IDLE=2'b00, S_XFER=2'b01, S_FLUSH=2'b10, S_DONE=2'b11;
  - `DC_WR_BIT`=9;
  - `DC_LEN_LSB`=12, `DC_LEN_MSB`=23.
- **Sub-module `ss_write_stage`:** the data/last/pend stage register with load and retire. The FSM and `rem` counter remain in the top level.

## Test plan
- **Length 4:** `dc[23:12]`=4 with 6 words queued -> exactly 4 pushes on consecutive cycles, `m_dst_last`=1 only on the 4th, `m_endn` low for one cycle, 2 words left in the source.
- **Early end:** length 8 with `m_src_last` set on the 3rd word -> 3 pushes, last asserted on the 3rd push, `m_endn` pulse.
- **Backpressure:** `m_dst_almost_full` toggled every other cycle -> no pops while high, no lost or duplicated words, `m_dst_putn` never low while `m_dst_full`=1.
- **Length 0:** `dc[23:12]`=0 -> 4096 pushes, last on push 4096.
- **Abort:** `m_enable` dropped after 2 pops -> the in-flight word still pushes, no `m_endn`, FSM in IDLE.
- **Reset and deselect:** `wb_rstn_i` low mid-transfer -> all outputs at reset values immediately (asynchronous); `dc[9]`=0 -> all outputs high-Z.
